// File: rtl/sw_pkg.sv
// Shared switch definitions: flit type encoding, arbiter states and flit helpers.
package sw_pkg;

  localparam int NPORT  = 4;
  localparam int FLIT_W = 10;

  localparam logic [1:0] FT_EMPTY = 2'b00;
  localparam logic [1:0] FT_HEAD  = 2'b10;
  localparam logic [1:0] FT_BODY  = 2'b01;
  localparam logic [1:0] FT_TAIL  = 2'b11;

  typedef enum logic {ARB_IDLE, ARB_XFER} arb_state_e;

  function automatic logic [1:0] flit_type(input logic [FLIT_W-1:0] f);
    return f[FLIT_W-1 -: 2];
  endfunction

endpackage

// File: rtl/sw_rrpick.sv
// Combinational 4-way round-robin picker: first set req bit at or after ptr, wrapping.
module sw_rrpick
  import sw_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] pick,
  output logic       any
);

  logic [1:0] idx;

  always_comb begin
    pick = '0;
    idx  = '0;
    any  = |req;
    // Walk farthest offset first so the closest requester to ptr overwrites last.
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) pick = idx;
    end
  end

endmodule

// File: rtl/sw_outarb.sv
// Per-output-port packet arbiter: owns one input for a whole packet, forwards its
// flits through a registered output and rotates priority between packets.
module sw_outarb
  import sw_pkg::*;
#(
  parameter int NPORT  = 4,
  parameter int FLITW  = FLIT_W,
  parameter int MAXLEN = 16,
  parameter int MYPORT = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NPORT-1:0]       req,
  input  logic [NPORT*FLITW-1:0] flit_i,
  output logic [NPORT-1:0]       ack,
  output logic [NPORT-1:0]       gnt,
  output logic [1:0]             sel,
  output logic [FLITW-1:0]       o,
  output logic                   busy,
  output logic                   abort
);

  localparam int CNTW = $clog2(MAXLEN) + 1;

  arb_state_e             state_q, state_d;
  logic [NPORT-1:0]       gnt_q, gnt_d;
  logic [1:0]             sel_q, sel_d;
  logic [1:0]             ptr_q, ptr_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic [FLITW-1:0]       o_q, o_d;
  logic                   abort_q, abort_d;
  logic [NPORT-1:0]       ack_c;

  logic [NPORT-1:0][FLITW-1:0] flits;
  logic [FLITW-1:0]       cur_flit;
  logic [1:0]             cur_ft;
  logic                   cur_vld, cur_tail, expire;
  logic [1:0]             pick;
  logic                   any;

  assign flits    = flit_i;
  assign cur_flit = flits[sel_q];
  assign cur_ft   = flit_type(cur_flit);
  assign cur_vld  = (cur_ft != FT_EMPTY);
  assign cur_tail = (cur_ft == FT_TAIL);
  assign expire   = (cnt_q == CNTW'(MAXLEN - 1));

  sw_rrpick u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .pick (pick),
    .any  (any)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    o_d     = '0;
    abort_d = 1'b0;
    ack_c   = '0;
    unique case (state_q)
      ARB_IDLE: begin
        if (any) begin
          gnt_d        = '0;
          gnt_d[pick]  = 1'b1;
          sel_d        = pick;
          cnt_d        = '0;
          state_d      = ARB_XFER;
        end
      end
      ARB_XFER: begin
        cnt_d = cnt_q + 1'b1;
        // A trailer on the expiry cycle still closes the packet cleanly.
        if (cur_tail) begin
          ack_c   = gnt_q;
          o_d     = cur_flit;
          state_d = ARB_IDLE;
          gnt_d   = '0;
          ptr_d   = sel_q + 2'd1;
        end else if (expire) begin
          abort_d = 1'b1;
          state_d = ARB_IDLE;
          gnt_d   = '0;
          ptr_d   = sel_q + 2'd1;
        end else if (cur_vld) begin
          ack_c   = gnt_q;
          o_d     = cur_flit;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      o_q     <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
      abort_q <= abort_d;
    end
  end

  assign ack   = ack_c;
  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign o     = o_q;
  assign busy  = (state_q == ARB_XFER);
  assign abort = abort_q;

  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q))
    else $error("sw_outarb[%0d]: gnt not one-hot", MYPORT);
  a_ack_owner: assert property (@(posedge clk) disable iff (rst) (ack_c & ~gnt_q) == '0)
    else $error("sw_outarb[%0d]: ack from non-owner", MYPORT);

endmodule

// File: doc/sw_outarb.md
Name: sw_outarb

Overview:
- Per-output-port packet arbiter for the 4-way switch; one instance sits in front of each output port oN.
- Collects requests from the four input ports, grants one input at a time, and holds the grant for a whole packet (header through trailer).
- Pops flits from the granted input, drives the registered output flit, and rotates priority round-robin between packets.
- A watchdog frees the port if a packet never delivers its trailer.

Parameters:
- NPORT, 4, number of input requesters (fixed 4; `sel` width is 2).
- FLITW, 10, flit width; bits [FLITW-1:FLITW-2] are the flit type.
- MAXLEN, 16, watchdog limit in cycles spent in XFER without a trailer.
- MYPORT, 0, index of the output port this instance serves (informational; used in assertions only).

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: reset, asynchronous, active-high (`ASSERT=1).
- req, input, NPORT: req[i]=1 means input i's head flit is a header addressed to this port.
- flit_i, input, NPORT*FLITW: head-of-queue flit per input; input 0 occupies bits [FLITW-1:0].
- ack, output, NPORT: one-hot pop strobe; ack[i]=1 means input i's head flit is consumed this cycle.
- gnt, output, NPORT: one-hot current owner; 0 when idle.
- sel, output, 2: index of the owner; holds its last value when idle.
- o, output, FLITW: registered output flit; 0 (empty) when nothing is forwarded.
- busy, output, 1: 1 while in XFER.
- abort, output, 1: one-cycle pulse on watchdog expiry.

Behaviour:
- Flit types: 00 empty, 10 header, 01 payload, 11 trailer. "Valid" means type != 00.
- Reset (asynchronous): state=IDLE; gnt=0, sel=0, o=0, busy=0, abort=0, rr pointer ptr=0, watchdog cnt=0. Reset mid-packet drops the packet; no trailer is emitted.
- IDLE state:
  - ack=0.
  - If req!=0, pick the first set bit searching ptr, ptr+1, … mod 4.
  - Next edge: gnt<=onehot(pick), sel<=pick, cnt<=0, state<=XFER, busy<=1.
  - req sampled at edge N gives gnt visible after edge N.
- XFER state:
  - ack = gnt & {4{valid(flit_i[sel])}}, combinational.
  - Each edge: o <= ack[sel] ? flit_i[sel] : 0. Output latency is 1 cycle from ack.
  - Empty flits are not acked and do not end the packet.
  - req is ignored while busy, including deassertion by the owner.
- Packet end (acked flit is a trailer, type 11):
  - That edge: o<=trailer, state<=IDLE, gnt<=0, busy<=0, ptr<=(sel+1) mod 4.
  - The next arbitration happens in the following IDLE cycle, so there is a minimum 1-cycle gap between the grants of consecutive packets.
  - A trailer acked as the first flit is accepted as a complete 1-flit packet.
- Header while already owning: a header (type 10) acked after the first flit is forwarded unchanged. Headers are not checked inside XFER.
- Watchdog:
  - cnt increments every XFER cycle and clears on the transition into XFER.
  - When cnt==MAXLEN-1 and no trailer is acked that cycle: abort<=1 for one cycle, o<=0, ack=0 that cycle, state<=IDLE, gnt<=0, ptr<=(sel+1) mod 4.
  - A trailer on the same cycle as expiry wins: normal end, no abort.
- Round-robin fairness: with all four requesting continuously, owners rotate 0,1,2,3,0 starting from ptr.
- Widths: ptr and sel are 2 bits and wrap 3→0; cnt is $clog2(MAXLEN)+1 bits.

Decomposition:
- Shared package sw_pkg holds:
  - Flit type constants FT_EMPTY=2'b00, FT_HEAD=2'b10, FT_BODY=2'b01, FT_TAIL=2'b11.
  - NPORT.
  - Arbiter state enum {ARB_IDLE, ARB_XFER}.
  - A function returning the type field of a flit.
- Sub-module sw_rrpick: combinational 4-way round-robin picker.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: pick[1:0], any.
  - Reused by later per-port schedulers.

Test Plan:
- Single 4-flit packet:
  - Stimulus: req=0001 at edge 1; flit_i[0] = 10'b10_0000_0001, 10'b01_0000_0000, 10'b01_0000_0001, 10'b11_0000_0010 on successive cycles.
  - Response: gnt=0001 after edge 1; ack[0]=1 for 4 cycles; o repeats those flits 1 cycle later; busy drops with the trailer; ptr=1.
- Four-way conflict:
  - Stimulus: req=1111 held; each input sends a 2-flit packet 10_xxxx_0001 then 11_xxxx_1111.
  - Response: grants in order 0001, 0010, 0100, 1000; a 1-cycle IDLE gap between each; no flit from a non-owner appears on o.
- Bubbles inside a packet:
  - Stimulus: owner 2 presents header, empty, empty, payload, trailer.
  - Response: ack[2]=0 during the empties; o=0 on the following cycles; the packet completes intact with no abort.
- Watchdog:
  - Stimulus: owner 1 sends a header then only payload flits; MAXLEN=16.
  - Response: abort=1 exactly 16 cycles after gnt=0010; gnt then 0, o=0, ptr=2; a pending req[3] is granted next.
- Reset mid-packet:
  - Stimulus: assert rst asynchronously between edges after the header and one payload.
  - Response: gnt, o, busy, ack all 0 immediately; after release the first grant goes to the lowest requester from ptr=0.
- Trailer-first / expiry tie:
  - Stimulus: a 1-flit trailer packet; separately, a trailer arriving on cycle MAXLEN-1.
  - Response: both end normally with abort=0.
